rom_load_ctrl: RTL and testbench
================================

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: number of clk cycles cpu_reset stays high after load or reset ends.
REQ-002 SHALL have parameter ROM_AW, default 15: instruction ROM word-address width.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  high while the MiSTer ioctl download is in progress.
REQ-006 ioctl_addr  in  16  byte address of the current ioctl byte.
REQ-007 ioctl_din  in  8  ioctl data byte.
REQ-008 ioctl_wr  in  1  single-cycle strobe; byte valid this cycle.
REQ-009 rom_addr  out  ROM_AW  instruction ROM write word address.
REQ-010 rom_data  out  16  instruction ROM write data.
REQ-011 rom_we  out  1  single-cycle ROM write enable.
REQ-012 cpu_reset  out  1  reset to CPU; high while loading or holding.
REQ-013 busy  out  1  high in every state except RUN.
REQ-014 word_count  out  16  words written in the current or last download.
REQ-015 load_err  out  1  sticky error flag; cleared at download start or reset.

Function
REQ-016 States SHALL be HOLD, RUN, LOAD_HI, LOAD_LO; all outputs registered.
REQ-017 Bytes SHALL be big-endian: even ioctl_addr = instruction bits [15:8], odd = bits [7:0].
REQ-018 Rising edge of ioctl_download (low last cycle, high this cycle), from any state, SHALL enter LOAD_HI, clear word_count and load_err, and set cpu_reset.
REQ-019 In LOAD_HI, ioctl_wr with even address SHALL latch high byte and word address ioctl_addr[ROM_AW:1], then go LOAD_LO.
REQ-020 In LOAD_HI, ioctl_wr with odd address SHALL drop the byte, set load_err, and stay in LOAD_HI.
REQ-021 In LOAD_LO, ioctl_wr with address equal to latched byte address + 1 SHALL drive rom_data={hi,din} and rom_addr, and pulse rom_we the next cycle; it SHALL also increment word_count (saturating at 0xFFFF) and return to LOAD_HI.
REQ-022 In LOAD_LO, ioctl_wr with any other address SHALL set load_err and drop the pending high byte. If that new byte is even, it SHALL be latched as the new high byte and the state SHALL stay LOAD_LO; otherwise the state SHALL go to LOAD_HI.
REQ-023 Falling edge of ioctl_download in LOAD_LO SHALL write the pending word with low byte 0x00 (one rom_we pulse) and set load_err.
REQ-024 Falling edge of ioctl_download in LOAD_HI/LOAD_LO SHALL enter HOLD with hold counter = HOLD_CYCLES.
REQ-025 ioctl_wr and the download falling edge in the same cycle SHALL process the byte first, then apply REQ-023/024.
REQ-026 HOLD SHALL decrement the counter each cycle and enter RUN when it reaches 0.
REQ-027 In RUN, cpu_reset=0 and busy=0; ioctl_wr with ioctl_download low SHALL be ignored.
REQ-028 rom_we SHALL never be high for two consecutive cycles; rom_addr/rom_data SHALL be stable while rom_we=1.
REQ-029 A word address beyond 2^ROM_AW-1 SHALL be impossible: the address is truncated to ROM_AW bits.

Reset
REQ-030 reset SHALL force state=HOLD, hold counter=HOLD_CYCLES, cpu_reset=1, busy=1, rom_we=0, rom_addr=0, rom_data=0, word_count=0, load_err=0.
REQ-031 reset mid-download SHALL abandon any pending high byte without a ROM write; the sampled ioctl_download edge register SHALL reset to 0.

Structure
REQ-032 State encoding, ROM_AW default and HOLD_CYCLES default SHALL live in the shared hack_pkg package.
REQ-033 No sub-module; single module with one FSM, one hold counter, one byte latch.

Verification
REQ-034 Reset, no download -> cpu_reset=1 for exactly 16 cycles after reset drops, then RUN, busy=0.
REQ-035 Download bytes 0x12@0, 0x34@1, 0xAB@2, 0xCD@3 -> rom_we pulses: addr 0 data 0x1234, addr 1 data 0xABCD; word_count=2, load_err=0.
REQ-036 Download 3 bytes 0xFF@0, 0xEE@1, 0x77@2, then ioctl_download falls -> final write addr 1 data 0x7700, load_err=1, then HOLD 16 cycles.
REQ-037 Byte at addr 1 first, then 0x00@2, 0x01@3 -> addr-1 byte dropped, load_err=1, write addr 1 data 0x0001.
REQ-038 reset asserted after 0x55@0 in LOAD_LO -> no rom_we, state HOLD, word_count=0.
REQ-039 New download rising edge while in RUN -> cpu_reset=1 next cycle, word_count and load_err cleared.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the ROM loader: FSM encoding, default geometry, helpers.
// Pure declarations; no clocked logic, latency or flow control of its own.
package hack_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_LOAD_HI = 2'd2,
    ST_LOAD_LO = 2'd3
  } state_t;

  localparam int ROM_AW_DEF      = 15;
  localparam int HOLD_CYCLES_DEF = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rom_load_ctrl.sv
// Packs big-endian ioctl download bytes into 16-bit ROM writes and holds the CPU in reset around loads.
// ROM write one cycle after the completing byte; no backpressure, ioctl must not outpace one byte/cycle.
module rom_load_ctrl
  import hack_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int ROM_AW      = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_addr,
  input  logic [7:0]        ioctl_din,
  input  logic              ioctl_wr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic [15:0]       word_count,
  output logic              load_err
);

  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

  state_t            state_q, state_d;
  logic [15:0]       hold_q, hold_d;
  logic              dl_q, dl_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       baddr_q, baddr_d;
  logic [ROM_AW-1:0] waddr_q, waddr_d;
  logic              flush_q, flush_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_data_q, rom_data_d;
  logic              rom_we_q, rom_we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic [15:0]       wc_q, wc_d;
  logic              err_q, err_d;

  logic dl_rise, dl_fall, in_load;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign in_load = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    dl_d        = ioctl_download;
    hi_d        = hi_q;
    baddr_d     = baddr_q;
    waddr_d     = waddr_q;
    flush_d     = 1'b0;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_data_d  = rom_data_q;
    wc_d        = wc_q;
    err_d       = err_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;

    if (state_q == ST_HOLD) begin
      if (hold_q <= 16'd1) begin
        hold_d  = '0;
        state_d = ST_RUN;
      end else begin
        hold_d = hold_q - 16'd1;
      end
    end

    // A truncated final word that collided with the previous write goes out one cycle late.
    if (flush_q) begin
      rom_we_d   = 1'b1;
      rom_addr_d = waddr_q;
      rom_data_d = {hi_q, 8'h00};
    end

    if (dl_rise) begin
      state_d = ST_LOAD_HI;
      wc_d    = '0;
      err_d   = 1'b0;
    end

    if (ioctl_wr) begin
      case (state_d)
        ST_LOAD_HI: begin
          if (!ioctl_addr[0]) begin
            hi_d    = ioctl_din;
            baddr_d = ioctl_addr;
            waddr_d = ROM_AW'(ioctl_addr >> 1);
            state_d = ST_LOAD_LO;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_LOAD_LO: begin
          if (ioctl_addr == baddr_q + 16'd1) begin
            rom_we_d   = 1'b1;
            rom_addr_d = waddr_q;
            rom_data_d = {hi_q, ioctl_din};
            wc_d       = sat_inc16(wc_d);
            state_d    = ST_LOAD_HI;
          end else begin
            err_d = 1'b1;
            if (!ioctl_addr[0]) begin
              hi_d    = ioctl_din;
              baddr_d = ioctl_addr;
              waddr_d = ROM_AW'(ioctl_addr >> 1);
            end else begin
              state_d = ST_LOAD_HI;
            end
          end
        end
        default: ;
      endcase
    end

    if (dl_fall && in_load) begin
      if (state_d == ST_LOAD_LO) begin
        err_d = 1'b1;
        wc_d  = sat_inc16(wc_d);
        if (rom_we_q) begin
          flush_d = 1'b1;
        end else begin
          rom_we_d   = 1'b1;
          rom_addr_d = waddr_d;
          rom_data_d = {hi_d, 8'h00};
        end
      end
      state_d = ST_HOLD;
      hold_d  = HOLD_INIT;
    end

    cpu_reset_d = (state_d != ST_RUN);
    busy_d      = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= HOLD_INIT;
      dl_q        <= 1'b0;
      hi_q        <= '0;
      baddr_q     <= '0;
      waddr_q     <= '0;
      flush_q     <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      wc_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      dl_q        <= dl_d;
      hi_q        <= hi_d;
      baddr_q     <= baddr_d;
      waddr_q     <= waddr_d;
      flush_q     <= flush_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      wc_q        <= wc_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign rom_we     = rom_we_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign word_count = wc_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: directed scenarios plus randomized downloads checked against a byte-level model.
module tb_rom_load_ctrl;

  localparam int AW = 15;
  localparam int HC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic [15:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wr;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          rom_we;
  logic          cpu_reset;
  logic          busy;
  logic [15:0]   word_count;
  logic          load_err;

  always #5 clk = ~clk;

  rom_load_ctrl #(.HOLD_CYCLES(HC), .ROM_AW(AW)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wr(ioctl_wr), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_we(rom_we), .cpu_reset(cpu_reset), .busy(busy), .word_count(word_count),
    .load_err(load_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed and predicted ROM writes as {word address, data}.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (rom_we) begin
      check("we_not_b2b", {31'd0, prev_we}, 32'd0);
      got_q.push_back({16'(rom_addr), rom_data});
    end
    prev_we = rom_we;
  end

  // Byte-level reference: pending high byte, error flag, word count.
  bit          m_pend;
  logic [7:0]  m_hi;
  logic [15:0] m_baddr;
  logic [15:0] m_wc;
  bit          m_err;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [15:0] mask;
    mask = 16'((32'h1 << AW) - 1);
    return (a >> 1) & mask;
  endfunction

  task automatic m_count();
    if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
  endtask

  task automatic model_byte(input logic [15:0] a, input logic [7:0] d);
    if (!m_pend) begin
      if (a[0]) m_err = 1;
      else begin m_pend = 1; m_hi = d; m_baddr = a; end
    end else if (a == m_baddr + 16'd1) begin
      exp_q.push_back({word_of(m_baddr), m_hi, d});
      m_count();
      m_pend = 0;
    end else begin
      m_err = 1;
      if (a[0]) m_pend = 0;
      else begin m_hi = d; m_baddr = a; end
    end
  endtask

  task automatic model_fall();
    if (m_pend) begin
      exp_q.push_back({word_of(m_baddr), m_hi, 8'h00});
      m_err = 1;
      m_count();
      m_pend = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
    m_pend = 0; m_wc = 0; m_err = 0;
  endtask

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input int gap);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_din = d;
    tick();
    ioctl_wr = 1'b0;
    model_byte(a, d);
    repeat (gap) tick();
  endtask

  task automatic end_dl(input bit with_byte, input logic [15:0] a, input logic [7:0] d);
    if (with_byte) begin ioctl_wr = 1'b1; ioctl_addr = a; ioctl_din = d; end
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    if (with_byte) model_byte(a, d);
    model_fall();
  endtask

  // Counts cpu_reset-high samples from now until RUN; bounded.
  task automatic check_hold(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_reset) n++;
      else break;
    end
    check(tag, n, HC);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_wr"}, got_q[i], exp_q[i]);
    check({tag, "_wc"}, {16'd0, word_count}, {16'd0, m_wc});
    check({tag, "_err"}, {31'd0, load_err}, {31'd0, m_err});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_din = '0;
    m_pend = 0; m_hi = '0; m_baddr = '0; m_wc = '0; m_err = 0;
    tick(); tick();
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rom_we", {31'd0, rom_we}, 32'd0);
    check("rst_rom_addr", {17'd0, rom_addr}, 32'd0);
    check("rst_rom_data", {16'd0, rom_data}, 32'd0);
    check("rst_word_count", {16'd0, word_count}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    reset = 1'b0;
    check_hold("rst_hold");

    // Two clean words.
    tick();
    start_dl();
    send_byte(16'd0, 8'h12, 1); send_byte(16'd1, 8'h34, 0);
    send_byte(16'd2, 8'hAB, 2); send_byte(16'd3, 8'hCD, 0);
    end_dl(0, '0, '0);
    check_hold("clean_hold");
    check("clean_wc", {16'd0, word_count}, 32'd2);
    compare_writes("clean");

    // Odd byte count: truncated final word.
    tick();
    start_dl();
    send_byte(16'd0, 8'hFF, 0); send_byte(16'd1, 8'hEE, 1); send_byte(16'd2, 8'h77, 1);
    end_dl(0, '0, '0);
    check_hold("trunc_hold");
    check("trunc_err", {31'd0, load_err}, 32'd1);
    compare_writes("trunc");

    // New download from RUN clears status.
    tick();
    start_dl();
    @(negedge clk);
    check("rise_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rise_wc", {16'd0, word_count}, 32'd0);
    check("rise_err", {31'd0, load_err}, 32'd0);
    tick();

    // Leading odd byte dropped.
    send_byte(16'd1, 8'h99, 0); send_byte(16'd2, 8'h00, 1); send_byte(16'd3, 8'h01, 0);
    end_dl(0, '0, '0);
    check_hold("odd_hold");
    compare_writes("odd");

    // Word completes, then an even byte arrives with the falling edge.
    tick();
    start_dl();
    send_byte(16'd0, 8'h12, 0); send_byte(16'd1, 8'h34, 0);
    end_dl(1, 16'd2, 8'h56);
    check_hold("same_hold");
    compare_writes("same");

    // Reset with a pending high byte.
    tick();
    start_dl();
    send_byte(16'd0, 8'h55, 0);
    reset = 1'b1; ioctl_download = 1'b0;
    tick(); tick();
    m_pend = 0; m_wc = 0; m_err = 0;
    check("rstmid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    compare_writes("rstmid");
    check_hold("rstmid_hold");

    // Randomized downloads with occasional address faults.
    for (int t = 0; t < 25; t++) begin
      int nb;
      logic [15:0] base, a;
      tick();
      start_dl();
      nb   = $urandom_range(0, 12);
      base = 16'($urandom) & 16'hFFFE;
      for (int k = 0; k < nb; k++) begin
        a = base + 16'(k);
        if ($urandom_range(0, 9) == 0) a = 16'($urandom);
        send_byte(a, 8'($urandom), $urandom_range(0, 2));
      end
      @(negedge clk);
      check("rand_busy", {31'd0, busy}, 32'd1);
      tick();
      a = base + 16'(nb);
      end_dl($urandom_range(0, 3) == 0, a, 8'($urandom));
      check_hold("rand_hold");
      compare_writes("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
